multiway_traffic_controller: RTL and testbench

- Parametrised successor to the one-way traffic light controller: drives N_WAYS approaches at one junction, one GREEN at a time.
- Time base is an external tick strobe. Phase durations are set by parameters.
- Vehicle-sensor requests select the next way round-robin; ways with no request are skipped.
- Flash (night/fault) mode puts every approach on flashing YELLOW, with safe entry and exit.

---
 rtl/multiway_traffic_controller_pkg.sv | 28 ++
 rtl/multiway_traffic_controller_rr_next_way.sv | 38 +++
 rtl/multiway_traffic_controller.sv | 152 +++++++++++++++
 tb/tb_multiway_traffic_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/multiway_traffic_controller_pkg.sv
// Shared lamp/phase encodings and default phase durations for the junction controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake).
package traffic_pkg;

  // Per-way lamp code driven on the light bus.
  typedef enum logic [1:0] {
    LAMP_RED    = 2'b00,
    LAMP_YELLOW = 2'b01,
    LAMP_GREEN  = 2'b10,
    LAMP_OFF    = 2'b11
  } lamp_e;

  // Controller state; the phase output carries this code unchanged.
  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_FLASH   = 2'd3
  } phase_e;

  localparam int DEF_N_WAYS       = 4;
  localparam int DEF_GREEN_TICKS  = 8;
  localparam int DEF_YELLOW_TICKS = 3;
  localparam int DEF_ALLRED_TICKS = 2;
  localparam int DEF_FLASH_TICKS  = 4;

endpackage

// File: rtl/multiway_traffic_controller_rr_next_way.sv
// Round-robin next-way selector: first requesting way after active_way, active_way itself last.
// Latency: purely combinational. Falls back to active_way+1 when nobody is requesting.
// Backpressure: none. Ports: req (per-way level), active_way (last served) -> next_way.
module rr_next_way
  import traffic_pkg::*;
#(
  parameter int N_WAYS = DEF_N_WAYS
)
(
  input  logic [N_WAYS-1:0]         req,
  input  logic [$clog2(N_WAYS)-1:0] active_way,
  output logic [$clog2(N_WAYS)-1:0] next_way
);

  localparam int WW = $clog2(N_WAYS);

  logic [WW-1:0] fallback;
  logic          found;
  int            idx;

  // Wrap explicitly so non-power-of-two way counts stay in range.
  assign fallback = (active_way == WW'(N_WAYS - 1)) ? '0 : active_way + 1'b1;

  always_comb begin
    next_way = fallback;
    found    = 1'b0;
    idx      = 0;
    for (int i = 1; i <= N_WAYS; i++) begin
      idx = int'(active_way) + i;
      if (idx >= N_WAYS) idx = idx - N_WAYS;
      if (!found && req[idx[WW-1:0]]) begin
        next_way = idx[WW-1:0];
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiway_traffic_controller.sv
// N-way junction controller: one GREEN at a time, round-robin on sensor requests, flash mode.
// Latency: a tick at cnt==0 moves state; new lamps show at that same edge (one cycle after decision).
// Backpressure: tick=0 freezes timing; flash_req in GREEN forces YELLOW immediately.
// Ports: clk/reset (sync, high), tick, req[N_WAYS], flash_req -> light[N_WAYS][2],
//        active_way, phase (state code), phase_done (pulse after each state change/flash toggle).
module multiway_traffic_controller
  import traffic_pkg::*;
#(
  parameter int N_WAYS       = DEF_N_WAYS,
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int FLASH_TICKS  = DEF_FLASH_TICKS
)
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic [N_WAYS-1:0]              req,
  input  logic                           flash_req,
  output logic [N_WAYS-1:0][1:0]         light,
  output logic [$clog2(N_WAYS)-1:0]      active_way,
  output logic [1:0]                     phase,
  output logic                           phase_done
);

  localparam int WW      = $clog2(N_WAYS);
  localparam int MAX_GY  = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_AF  = (ALLRED_TICKS > FLASH_TICKS) ? ALLRED_TICKS : FLASH_TICKS;
  localparam int MAX_DUR = (MAX_GY > MAX_AF) ? MAX_GY : MAX_AF;
  localparam int CNT_W   = $clog2(MAX_DUR) + 1;

  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_LOAD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] F_LOAD = CNT_W'(FLASH_TICKS - 1);

  localparam logic [1:0] S_ALL_RED = PH_ALL_RED;
  localparam logic [1:0] S_GREEN   = PH_GREEN;
  localparam logic [1:0] S_YELLOW  = PH_YELLOW;
  localparam logic [1:0] S_FLASH   = PH_FLASH;

  logic [1:0]             state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [WW-1:0]          way_n, rr_way;
  logic                   flash_off, flash_off_n;  // 0 = yellow half, 1 = dark half
  logic                   chg;
  logic                   expire;
  logic [N_WAYS-1:0][1:0] light_n;

  rr_next_way #(.N_WAYS(N_WAYS)) u_rr (
    .req        (req),
    .active_way (active_way),
    .next_way   (rr_way)
  );

  assign expire = tick && (cnt == '0);
  assign phase  = state;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    way_n       = active_way;
    flash_off_n = flash_off;
    chg         = 1'b0;
    case (state)
      S_ALL_RED: begin
        if (expire) begin
          chg = 1'b1;
          if (flash_req) begin
            state_n     = S_FLASH;
            cnt_n       = F_LOAD;
            flash_off_n = 1'b0;
          end else begin
            state_n = S_GREEN;
            cnt_n   = G_LOAD;
            way_n   = rr_way;
          end
        end else if (tick) begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_GREEN: begin
        // Flash request cuts GREEN short but still walks through YELLOW and ALL_RED.
        if (flash_req || expire) begin
          chg     = 1'b1;
          state_n = S_YELLOW;
          cnt_n   = Y_LOAD;
        end else if (tick) begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_YELLOW: begin
        if (expire) begin
          chg     = 1'b1;
          state_n = S_ALL_RED;
          cnt_n   = A_LOAD;
        end else if (tick) begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin  // S_FLASH
        if (expire) begin
          chg   = 1'b1;
          if (!flash_req) begin
            state_n     = S_ALL_RED;
            cnt_n       = A_LOAD;
            flash_off_n = 1'b0;
          end else begin
            cnt_n       = F_LOAD;
            flash_off_n = ~flash_off;
          end
        end else if (tick) begin
          cnt_n = cnt - 1'b1;
        end
      end
    endcase
  end

  // Lamps are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    light_n = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      light_n[w] = LAMP_RED;
      case (state_n)
        S_GREEN:  if (WW'(w) == way_n) light_n[w] = LAMP_GREEN;
        S_YELLOW: if (WW'(w) == way_n) light_n[w] = LAMP_YELLOW;
        S_FLASH:  light_n[w] = flash_off_n ? LAMP_OFF : LAMP_YELLOW;
        default:  light_n[w] = LAMP_RED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_ALL_RED;
      cnt        <= A_LOAD;
      active_way <= WW'(N_WAYS - 1);
      flash_off  <= 1'b0;
      light      <= '0;
      phase_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      active_way <= way_n;
      flash_off  <= flash_off_n;
      light      <= light_n;
      phase_done <= chg;
    end
  end

endmodule

// File: tb/tb_multiway_traffic_controller.sv
// Directed bench for the junction controller: 4-way and 2-way instances on one clock.
// Latency: n/a. Backpressure: n/a.
// Outputs sampled on the falling edge; inputs driven from the falling edge.
module tb_multiway_traffic_controller;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic [3:0]       req4;
  logic [1:0]       req2;
  logic             flash4;
  logic             flash2;
  logic [3:0][1:0]  light4;
  logic [1:0][1:0]  light2;
  logic [1:0]       aw4;
  logic [0:0]       aw2;
  logic [1:0]       ph4, ph2;
  logic             pd4, pd2;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;
  logic [1:0] prev4 = 2'd0;
  logic [1:0] prev2 = 2'd0;

  always #5 clk = ~clk;

  multiway_traffic_controller u_dut4 (
    .clk(clk), .reset(reset), .tick(tick), .req(req4), .flash_req(flash4),
    .light(light4), .active_way(aw4), .phase(ph4), .phase_done(pd4)
  );

  multiway_traffic_controller #(.N_WAYS(2)) u_dut2 (
    .clk(clk), .reset(reset), .tick(tick), .req(req2), .flash_req(flash2),
    .light(light2), .active_way(aw2), .phase(ph2), .phase_done(pd2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // kind: 0 all red, 1 way green, 2 way yellow, 3 all yellow, 4 all off
  function automatic logic [31:0] lv(input int n, input int kind, input int way);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      case (kind)
        1: if (i == way) v[2*i +: 2] = 2'b10;
        2: if (i == way) v[2*i +: 2] = 2'b01;
        3: v[2*i +: 2] = 2'b01;
        4: v[2*i +: 2] = 2'b11;
        default: v[2*i +: 2] = 2'b00;
      endcase
    end
    return v;
  endfunction

  // Safety monitor: never two greens, GREEN only entered from ALL_RED.
  always @(negedge clk) begin
    int ng4;
    int ng2;
    if (mon_en) begin
      ng4 = 0;
      ng2 = 0;
      for (int i = 0; i < 4; i++) if (light4[i] == 2'b10) ng4++;
      for (int i = 0; i < 2; i++) if (light2[i] == 2'b10) ng2++;
      chk("one_green4", 32'(ng4 <= 1), 32'd1);
      chk("one_green2", 32'(ng2 <= 1), 32'd1);
      if (ph4 == 2'd1 && prev4 != 2'd1) chk("green_entry4", 32'(prev4), 32'd0);
      if (ph2 == 2'd1 && prev2 != 2'd1) chk("green_entry2", 32'(prev2), 32'd0);
    end
    prev4 = ph4;
    prev2 = ph2;
  end

  // Called at a falling edge; leaves the bench at the falling edge of cycle 0.
  task automatic rst_seq();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Normal timeline from cycle 0: 2 red, then slots of 8 G / 3 Y / 2 R.
  // Way per slot for the 4-way unit comes from w0..w3; the 2-way unit (req=10) always serves way 1.
  task automatic run_seq(input int ncyc, input int w0, input int w1, input int w2, input int w3);
    int ws[4];
    int kind, ph, pd, w, pos, r;
    ws = '{w0, w1, w2, w3};
    for (int c = 0; c < ncyc; c++) begin
      if (c < 2) begin
        kind = 0; ph = 0; pd = 0; w = 3;
      end else begin
        pos  = c - 2;
        r    = pos % 13;
        w    = ws[(pos / 13) % 4];
        kind = (r < 8) ? 1 : (r < 11) ? 2 : 0;
        ph   = kind;
        pd   = (r == 0 || r == 8 || r == 11) ? 1 : 0;
      end
      chk("light4", 32'(light4), lv(4, kind, w));
      chk("way4",   32'(aw4), 32'(w));
      chk("phase4", 32'(ph4), 32'(ph));
      chk("done4",  32'(pd4), 32'(pd));
      chk("light2", 32'(light2), lv(2, kind, 1));
      chk("way2",   32'(aw2), 32'd1);
      chk("done2",  32'(pd2), 32'(pd));
      @(negedge clk);
    end
  endtask

  initial begin
    reset  = 1'b1;
    tick   = 1'b1;
    req4   = 4'b1111;
    req2   = 2'b10;
    flash4 = 1'b0;
    flash2 = 1'b0;
    @(negedge clk);

    // Round robin over all four ways, wrapping back to way 0.
    rst_seq();
    mon_en = 1'b1;
    run_seq(2 + 13 * 5, 0, 1, 2, 3);

    // Only way 2 requesting: it is served every slot.
    req4 = 4'b0100;
    rst_seq();
    run_seq(2 + 13 * 2 + 1, 2, 2, 2, 2);

    // No requests: fixed-time order.
    req4 = 4'b0000;
    rst_seq();
    run_seq(2 + 13 * 4 + 1, 0, 1, 2, 3);

    // Tick freeze mid-GREEN: at cycle 5 four green ticks remain.
    req4 = 4'b1111;
    rst_seq();
    repeat (5) @(negedge clk);
    chk("frz_pre", 32'(light4), lv(4, 1, 0));
    tick = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("frz_light", 32'(light4), lv(4, 1, 0));
      chk("frz_done",  32'(pd4), 32'd0);
    end
    tick = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("frz_rem", 32'(light4), lv(4, 1, 0));
    end
    @(negedge clk);
    chk("frz_yel",  32'(light4), lv(4, 2, 0));
    chk("frz_ydone", 32'(pd4), 32'd1);

    // Flash request on the third GREEN cycle of way 0.
    rst_seq();
    repeat (4) @(negedge clk);
    flash4 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      int kind, ph, w, pd;
      @(negedge clk);
      w  = 0;
      if (k <= 3)       begin kind = 2; ph = 2; end
      else if (k <= 5)  begin kind = 0; ph = 0; end
      else if (k <= 9)  begin kind = 3; ph = 3; end
      else if (k <= 13) begin kind = 4; ph = 3; end
      else if (k <= 17) begin kind = 3; ph = 3; end
      else if (k <= 19) begin kind = 0; ph = 0; end
      else              begin kind = 1; ph = 1; w = 1; end
      pd = (k == 1 || k == 4 || k == 6 || k == 10 || k == 14 || k == 18 || k == 20) ? 1 : 0;
      chk("fl_light", 32'(light4), lv(4, kind, w));
      chk("fl_phase", 32'(ph4), 32'(ph));
      chk("fl_way",   32'(aw4), 32'(w));
      chk("fl_done",  32'(pd4), 32'(pd));
      if (k == 14) flash4 = 1'b0;
    end

    // Reset in the middle of YELLOW, then the normal timeline again.
    rst_seq();
    repeat (11) @(negedge clk);
    chk("ry_pre", 32'(light4), lv(4, 2, 0));
    reset = 1'b1;
    @(negedge clk);
    chk("ry_light", 32'(light4), 32'd0);
    chk("ry_phase", 32'(ph4), 32'd0);
    chk("ry_way",   32'(aw4), 32'd3);
    chk("ry_done",  32'(pd4), 32'd0);
    reset = 1'b0;
    run_seq(2 + 13 * 2, 0, 1, 2, 3);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
